// File: rtl/mcp3_ohc_chk.sv
`default_nettype none
// ============================================================================
// Module   : mcp3_ohc_chk
// Purpose  : Registered one-hot checker/encoder with sticky error flag,
//            saturating error counter and optional first-error capture.
//            Define MCP3_OHC_CAPTURE_EN to build the first-error capture
//            register; otherwise err_first_vector_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mcp3_ohc_chk #(
    parameter int WIDTH      = 5,
    parameter int ENC_WIDTH  = $clog2(WIDTH),
    parameter int CNT_WIDTH  = 8,
    parameter bit ALLOW_ZERO = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 check_valid_i,
    input  logic [WIDTH-1:0]     one_hot_vector_i,
    input  logic                 err_clear_i,
    output logic                 chk_valid_o,
    output logic                 one_hot_error_o,
    output logic [1:0]           err_type_o,
    output logic [ENC_WIDTH-1:0] one_hot_encoded_o,
    output logic                 err_sticky_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic [WIDTH-1:0]     err_first_vector_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 zero_hot_d;
    logic                 multi_hot_d;
    logic [ENC_WIDTH-1:0] enc_d;

    logic                 chk_valid_q;
    logic [1:0]           err_type_q;
    logic [ENC_WIDTH-1:0] enc_q;

    logic                 out_err;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;

    // Classify the incoming vector: prefix-OR scan flags any set bit that has
    // another set bit below it, and the encoder ORs in every set index (only
    // meaningful when exactly one bit is set, so it is masked otherwise).
    always_comb begin
        logic any_below;
        logic [ENC_WIDTH-1:0] enc_acc;
        any_below   = 1'b0;
        multi_hot_d = 1'b0;
        enc_acc     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            multi_hot_d = multi_hot_d | (one_hot_vector_i[i] & any_below);
            any_below   = any_below | one_hot_vector_i[i];
            if (one_hot_vector_i[i]) begin
                enc_acc = enc_acc | ENC_WIDTH'(i);
            end
        end
        zero_hot_d = ~any_below & ~ALLOW_ZERO;
        enc_d      = multi_hot_d ? '0 : enc_acc;
    end

    // Output stage: a non-qualified cycle registers nothing and zeros the stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chk_valid_q <= 1'b0;
            err_type_q  <= 2'b00;
            enc_q       <= '0;
        end else begin
            chk_valid_q <= check_valid_i;
            if (check_valid_i) begin
                err_type_q <= {multi_hot_d, zero_hot_d};
                enc_q      <= enc_d;
            end else begin
                err_type_q <= 2'b00;
                enc_q      <= '0;
            end
        end
    end

    assign out_err = chk_valid_q & (|err_type_q);

    // Status next-state: an output-stage error beats a simultaneous clear, in
    // which case the count restarts at one instead of continuing.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (out_err) begin
            sticky_d = 1'b1;
            if (err_clear_i) begin
                count_d = CNT_WIDTH'(1);
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (err_clear_i) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    // Status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

`ifdef MCP3_OHC_CAPTURE_EN
    logic [WIDTH-1:0] vec_q;
    logic [WIDTH-1:0] cap_q, cap_d;

    // Keep the sampled vector alongside the output stage for the capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vec_q <= '0;
        end else if (check_valid_i) begin
            vec_q <= one_hot_vector_i;
        end else begin
            vec_q <= '0;
        end
    end

    // Capture loads only the first error after a clear (or a colliding clear).
    always_comb begin
        cap_d = cap_q;
        if (out_err && (err_clear_i || !sticky_q)) begin
            cap_d = vec_q;
        end else if (err_clear_i && !out_err) begin
            cap_d = '0;
        end
    end

    // First-error capture register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    assign err_first_vector_o = cap_q;
`else
    assign err_first_vector_o = '0;
`endif

    assign chk_valid_o       = chk_valid_q;
    assign one_hot_error_o   = out_err;
    assign err_type_o        = err_type_q;
    assign one_hot_encoded_o = enc_q;
    assign err_sticky_o      = sticky_q;
    assign err_count_o       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp3_ohc_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcp3_ohc_chk
// Purpose  : Directed self-checking bench for mcp3_ohc_chk. Three instances
//            share stimulus: default, ALLOW_ZERO=1, and CNT_WIDTH=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcp3_ohc_chk;

`ifdef MCP3_OHC_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [4:0] vec = '0;
    logic       clr = 1'b0;

    logic       a_cv, a_err, a_st;
    logic [1:0] a_ty;
    logic [2:0] a_enc;
    logic [7:0] a_cnt;
    logic [4:0] a_cap;

    logic       z_cv, z_err, z_st;
    logic [1:0] z_ty;
    logic [2:0] z_enc;
    logic [7:0] z_cnt;
    logic [4:0] z_cap;

    logic       s_cv, s_err, s_st;
    logic [1:0] s_ty;
    logic [2:0] s_enc;
    logic [1:0] s_cnt;
    logic [4:0] s_cap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcp3_ohc_chk #(.WIDTH(5), .CNT_WIDTH(8), .ALLOW_ZERO(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .check_valid_i(vld), .one_hot_vector_i(vec),
        .err_clear_i(clr), .chk_valid_o(a_cv), .one_hot_error_o(a_err),
        .err_type_o(a_ty), .one_hot_encoded_o(a_enc), .err_sticky_o(a_st),
        .err_count_o(a_cnt), .err_first_vector_o(a_cap));

    mcp3_ohc_chk #(.WIDTH(5), .CNT_WIDTH(8), .ALLOW_ZERO(1'b1)) dut_z (
        .clk_i(clk), .rst_i(rst), .check_valid_i(vld), .one_hot_vector_i(vec),
        .err_clear_i(clr), .chk_valid_o(z_cv), .one_hot_error_o(z_err),
        .err_type_o(z_ty), .one_hot_encoded_o(z_enc), .err_sticky_o(z_st),
        .err_count_o(z_cnt), .err_first_vector_o(z_cap));

    mcp3_ohc_chk #(.WIDTH(5), .CNT_WIDTH(2), .ALLOW_ZERO(1'b0)) dut_s (
        .clk_i(clk), .rst_i(rst), .check_valid_i(vld), .one_hot_vector_i(vec),
        .err_clear_i(clr), .chk_valid_o(s_cv), .one_hot_error_o(s_err),
        .err_type_o(s_ty), .one_hot_encoded_o(s_enc), .err_sticky_o(s_st),
        .err_count_o(s_cnt), .err_first_vector_o(s_cap));

    // Advance one edge and settle 1 ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (a_cv !== 1'b0) begin errors++; $display("FAIL reset_cv got %b exp 0", a_cv); end
        checks++; if (a_err !== 1'b0 || a_ty !== 2'b00) begin errors++; $display("FAIL reset_err got %b/%b exp 0/00", a_err, a_ty); end
        checks++; if (a_enc !== 3'd0 || a_st !== 1'b0 || a_cnt !== 8'd0 || a_cap !== 5'd0) begin
            errors++; $display("FAIL reset_status got enc=%0d st=%b cnt=%0d cap=%b exp all 0", a_enc, a_st, a_cnt, a_cap); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_onehot();
        for (int i = 0; i < 5; i++) begin
            vld = 1'b1; vec = 5'd1 << i;
            step();
            checks++; if (a_cv !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL onehot_err[%0d] got cv=%b err=%b exp 1/0", i, a_cv, a_err); end
            checks++; if (a_enc !== 3'(i)) begin errors++; $display("FAIL onehot_enc[%0d] got %0d exp %0d", i, a_enc, i); end
        end
        vld = 1'b0; vec = '0;
        step();
        checks++; if (a_cnt !== 8'd0 || a_st !== 1'b0) begin errors++; $display("FAIL onehot_cnt got cnt=%0d st=%b exp 0/0", a_cnt, a_st); end
    endtask

    task automatic test_errors();
        vld = 1'b1; vec = 5'b00000;
        step();
        checks++; if (a_err !== 1'b1 || a_ty !== 2'b01) begin errors++; $display("FAIL zero_hot got err=%b ty=%b exp 1/01", a_err, a_ty); end
        checks++; if (z_err !== 1'b0 || z_enc !== 3'd0 || z_cv !== 1'b1) begin errors++; $display("FAIL allow_zero got err=%b enc=%0d cv=%b exp 0/0/1", z_err, z_enc, z_cv); end
        vec = 5'b10001;
        step();
        checks++; if (a_err !== 1'b1 || a_ty !== 2'b10 || a_enc !== 3'd0) begin errors++; $display("FAIL multi_hot got err=%b ty=%b enc=%0d exp 1/10/0", a_err, a_ty, a_enc); end
        checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL cnt_after_one got %0d exp 1", a_cnt); end
        vld = 1'b0; vec = '0;
        step();
        checks++; if (a_cnt !== 8'd2 || a_st !== 1'b1) begin errors++; $display("FAIL err_status got cnt=%0d st=%b exp 2/1", a_cnt, a_st); end
        checks++; if (a_cap !== 5'b00000) begin errors++; $display("FAIL first_vec got %b exp 00000", a_cap); end
        checks++; if (z_cnt !== 8'd1) begin errors++; $display("FAIL allow_zero_cnt got %0d exp 1", z_cnt); end
    endtask

    task automatic test_invalid();
        vld = 1'b0; vec = 5'b00000;
        step();
        checks++; if (a_cv !== 1'b0 || a_err !== 1'b0 || a_ty !== 2'b00) begin errors++; $display("FAIL invalid got cv=%b err=%b ty=%b exp 0/0/00", a_cv, a_err, a_ty); end
        step();
        checks++; if (a_cnt !== 8'd2) begin errors++; $display("FAIL invalid_cnt got %0d exp 2", a_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [0:5];
        exp_cnt[0] = 2'd0; exp_cnt[1] = 2'd1; exp_cnt[2] = 2'd2;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3; exp_cnt[5] = 2'd3;
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (s_cnt !== 2'd0 || s_st !== 1'b0 || s_cap !== 5'd0) begin errors++; $display("FAIL clear_before_sat got cnt=%0d st=%b cap=%b exp 0/0/0", s_cnt, s_st, s_cap); end
        for (int k = 0; k < 6; k++) begin
            vld = (k < 5); vec = (k < 5) ? 5'b00011 : 5'b00000;
            step();
            checks++; if (s_cnt !== exp_cnt[k]) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, s_cnt, exp_cnt[k]); end
        end
        checks++; if (s_st !== 1'b1 || s_cap !== (CAP ? 5'b00011 : 5'b00000)) begin errors++; $display("FAIL sat_status got st=%b cap=%b", s_st, s_cap); end
    endtask

    task automatic test_clear_collision();
        vld = 1'b1; vec = 5'b11000;
        step();
        vld = 1'b0; vec = '0; clr = 1'b1;
        step();
        checks++; if (s_cnt !== 2'd1 || s_st !== 1'b1) begin errors++; $display("FAIL collide got cnt=%0d st=%b exp 1/1", s_cnt, s_st); end
        checks++; if (s_cap !== (CAP ? 5'b11000 : 5'b00000)) begin errors++; $display("FAIL collide_cap got %b", s_cap); end
        step();
        clr = 1'b0;
        checks++; if (s_cnt !== 2'd0 || s_st !== 1'b0 || s_cap !== 5'd0) begin errors++; $display("FAIL clear_alone got cnt=%0d st=%b cap=%b exp 0/0/0", s_cnt, s_st, s_cap); end
    endtask

    task automatic test_reset_midstream();
        vld = 1'b1; vec = 5'b00011;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (a_cv !== 1'b0 || a_err !== 1'b0 || a_ty !== 2'b00 || a_enc !== 3'd0) begin
            errors++; $display("FAIL midreset_out got cv=%b err=%b ty=%b enc=%0d exp 0", a_cv, a_err, a_ty, a_enc); end
        checks++; if (a_st !== 1'b0 || a_cnt !== 8'd0 || a_cap !== 5'd0) begin
            errors++; $display("FAIL midreset_status got st=%b cnt=%0d cap=%b exp 0", a_st, a_cnt, a_cap); end
        @(negedge clk);
        rst = 1'b0;
        vec = 5'b00100;
        step();
        checks++; if (a_cv !== 1'b1 || a_err !== 1'b0 || a_enc !== 3'd2) begin errors++; $display("FAIL post_reset got cv=%b err=%b enc=%0d exp 1/0/2", a_cv, a_err, a_enc); end
        vld = 1'b0; vec = '0;
        step();
        checks++; if (a_cnt !== 8'd0 || a_st !== 1'b0) begin errors++; $display("FAIL post_reset_status got cnt=%0d st=%b exp 0/0", a_cnt, a_st); end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_errors();
        test_invalid();
        test_saturation();
        test_clear_collision();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
